// File: rtl/fft_spectrum_buf_ctrl.sv
// FFT output sink: framing check, |X|^2 pipeline, ping-pong spectrum RAM with consumer handshake.
// Build option FFT_HALF_SPECTRUM_EN stores only bins 0..FFT_N/2-1.
module fft_spectrum_buf_ctrl #(
   parameter int FFT_N = 128,
   parameter int DW    = 16,
   parameter int AW    = 7
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 fft_src_valid,
   input  logic                 fft_src_sop,
   input  logic                 fft_src_eop,
   input  logic signed [DW-1:0] fft_real,
   input  logic signed [DW-1:0] fft_imag,
   output logic                 fft_src_ready,
   output logic                 frame_rdy,
   output logic                 rd_bank,
   input  logic [AW-1:0]        rd_addr,
   output logic [2*DW:0]        rd_data,
   input  logic                 frame_ack,
   output logic                 frame_err,
   output logic [15:0]          frame_cnt
);

`ifdef FFT_HALF_SPECTRUM_EN
   localparam int BW = AW - 1;
`else
   localparam int BW = AW;
`endif
   localparam int MW = 2*DW + 1;
   localparam logic [AW-1:0] LAST_BIN = AW'(FFT_N - 1);

   typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

   state_t                 state, state_n;
   logic [AW-1:0]          bin_cnt, bin_cnt_n, beat_bin;
   logic                   wr_bank, wr_bank_n, rd_bank_n;
   logic [1:0]             bank_full, full_n;
   logic                   drain_cnt, drain_cnt_n;
   logic                   ready_n, err_n, commit, ack_ok, beat_wr, accept, store_beat;

   logic signed [2*DW-1:0] re_sq_p1, im_sq_p1;
   logic [AW-1:0]          addr_p1;
   logic                   bank_p1;
   logic                   vld_p1;

   logic [MW-1:0]          mem [0:(2**(BW+1))-1];

   // Squares are never negative, so zero-extending before the add is exact.
   function automatic logic [MW-1:0] mag_sum(input logic signed [2*DW-1:0] a,
                                             input logic signed [2*DW-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   assign accept    = fft_src_valid && fft_src_ready;
   assign frame_rdy = |bank_full;

`ifdef FFT_HALF_SPECTRUM_EN
   assign store_beat = beat_wr && !beat_bin[AW-1];
`else
   assign store_beat = beat_wr;
`endif

   always_comb begin
      state_n     = state;
      bin_cnt_n   = bin_cnt;
      drain_cnt_n = drain_cnt;
      err_n       = 1'b0;
      commit      = 1'b0;
      beat_wr     = 1'b0;
      beat_bin    = bin_cnt;
      case (state)
         IDLE: begin
            if (accept && fft_src_sop) begin
               if (fft_src_eop && FFT_N > 1) begin
                  err_n = 1'b1;
               end else begin
                  beat_wr   = 1'b1;
                  beat_bin  = '0;
                  bin_cnt_n = AW'(1);
                  state_n   = RECV;
               end
            end
         end
         RECV: begin
            if (accept) begin
               if (fft_src_sop) begin
                  err_n     = 1'b1;
                  beat_wr   = 1'b1;
                  beat_bin  = '0;
                  bin_cnt_n = AW'(1);
               end else if (bin_cnt == LAST_BIN) begin
                  if (fft_src_eop) begin
                     beat_wr     = 1'b1;
                     drain_cnt_n = 1'b0;
                     state_n     = DRAIN;
                  end else begin
                     err_n   = 1'b1;
                     state_n = IDLE;
                  end
               end else if (fft_src_eop) begin
                  err_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  beat_wr   = 1'b1;
                  bin_cnt_n = bin_cnt + AW'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_cnt) begin
               commit  = 1'b1;
               state_n = IDLE;
            end else begin
               drain_cnt_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      ack_ok = frame_ack && frame_rdy;
      full_n = bank_full;
      if (ack_ok) full_n[rd_bank] = 1'b0;
      if (commit) full_n[wr_bank] = 1'b1;
      wr_bank_n = commit ? ~wr_bank : wr_bank;
      // The offered bank follows commit order: a new commit is offered only if nothing older waits.
      rd_bank_n = rd_bank;
      if (commit && !full_n[~wr_bank]) rd_bank_n = wr_bank;
      else if (ack_ok)                 rd_bank_n = ~rd_bank;
      ready_n = (state_n == RECV) || (state_n == IDLE && !full_n[wr_bank_n]);
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state         <= IDLE;
         bin_cnt       <= '0;
         drain_cnt     <= 1'b0;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         bank_full     <= 2'b00;
         fft_src_ready <= 1'b0;
         frame_err     <= 1'b0;
         frame_cnt     <= '0;
         vld_p1        <= 1'b0;
         rd_data       <= '0;
      end else begin
         state         <= state_n;
         bin_cnt       <= bin_cnt_n;
         drain_cnt     <= drain_cnt_n;
         wr_bank       <= wr_bank_n;
         rd_bank       <= rd_bank_n;
         bank_full     <= full_n;
         fft_src_ready <= ready_n;
         frame_err     <= err_n;
         if (commit) frame_cnt <= frame_cnt + 16'd1;
         vld_p1        <= store_beat;
         rd_data       <= mem[{rd_bank, rd_addr[BW-1:0]}];
      end
   end

   // Stage 1: squares
   always_ff @(posedge sys_clk) begin
      re_sq_p1 <= (2*DW)'(fft_real) * (2*DW)'(fft_real);
      im_sq_p1 <= (2*DW)'(fft_imag) * (2*DW)'(fft_imag);
      addr_p1  <= beat_bin;
      bank_p1  <= wr_bank;
   end

   // Stage 2: sum written straight into the spectrum RAM
   always_ff @(posedge sys_clk) begin
      if (vld_p1) mem[{bank_p1, addr_p1[BW-1:0]}] <= mag_sum(re_sq_p1, im_sq_p1);
   end

endmodule

// File: doc/fft_spectrum_buf_ctrl.md
Name: fft_spectrum_buf_ctrl

Overview:
- Sink-side controller for the FFT IP-core output stream (Avalon-ST source: valid/ready/sop/eop, real/imag).
- Checks frame framing, computes per-bin magnitude-squared and writes it into an internal ping-pong spectrum RAM (2 banks x FFT_N words).
- Hands completed banks to a downstream consumer (display/analysis) with a ready/ack handshake.
- Back-pressures the FFT when no bank is free. Sits between the FFT core and the spectrum display logic, all on the 50 MHz system clock.

Parameters:
- FFT_N, 128, points per FFT frame; power of two, 8..1024.
- DW, 16, width of each of fft_real and fft_imag (signed two's complement).
- AW, 7, address width; equals log2(FFT_N).

Ports:
- sys_clk  in  1  system clock, 50 MHz; all logic on the rising edge.
- sys_rst  in  1  reset, synchronous, active-low.
- fft_src_valid  in  1  FFT output beat valid.
- fft_src_sop  in  1  first beat of an FFT frame.
- fft_src_eop  in  1  last beat of an FFT frame.
- fft_real  in  DW  signed real part.
- fft_imag  in  DW  signed imaginary part.
- fft_src_ready  out  1  controller accepts a beat this cycle.
- frame_rdy  out  1  a completed bank is available to the consumer.
- rd_bank  out  1  index of the bank offered to the consumer.
- rd_addr  in  AW  consumer read address (bin index).
- rd_data  out  2*DW+1  magnitude-squared of bin rd_addr in bank rd_bank; registered.
- frame_ack  in  1  one-cycle pulse: consumer is done with rd_bank.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  16  count of committed frames; wraps at 65535 to 0.

Behaviour:
- Reset (sys_rst=0 at a clock edge):
  - state=IDLE; both banks FREE; wr_bank=0.
  - fft_src_ready=0, frame_rdy=0, rd_bank=0, rd_data=0, frame_err=0, frame_cnt=0.
  - Pipeline valid bits cleared. A reset mid-frame discards the partial frame; RAM contents are not cleared.
- Accept: a beat is accepted when fft_src_valid && fft_src_ready.
- fft_src_ready is registered. It is 1 in IDLE when wr_bank is FREE, and always 1 in RECV. It is 0 in DRAIN, in IDLE with no free bank, and during reset.
- Writer FSM:
  - IDLE:
    - Accepted beat with sop: bin_cnt<=1, write bin 0 into wr_bank, go to RECV.
    - Accepted beat without sop: discarded silently.
    - Accepted beat with sop and eop together when FFT_N>1: frame_err, stay IDLE.
  - RECV:
    - Each accepted beat writes bin bin_cnt; bin_cnt increments.
    - Accepted eop with bin_cnt==FFT_N-1: go to DRAIN.
    - Accepted eop with bin_cnt<FFT_N-1: frame_err pulse, bank not committed, go to IDLE.
    - bin_cnt==FFT_N-1 without eop: frame_err, go to IDLE; the beat is discarded.
    - Accepted sop in RECV: frame_err pulse, restart at bin 0 in the same bank, stay in RECV.
  - DRAIN:
    - Waits 2 cycles for the magnitude pipeline to flush.
    - Then marks wr_bank FULL, frame_cnt+1, toggles wr_bank, and goes to IDLE.
- Magnitude pipeline:
  - Stage 1 registers re*re and im*im, each 2*DW bits signed.
  - Stage 2 registers their sum as unsigned 2*DW+1 bits and writes RAM[wr_bank][addr].
  - Beat-to-RAM-write latency is 2 cycles. No saturation; the full width is kept. Example: -32768^2 + -32768^2 = 2^31.
- Consumer side:
  - frame_rdy=1 whenever at least one bank is FULL.
  - rd_bank is the oldest FULL bank (commit order tracked).
  - frame_ack while frame_rdy=1 sets rd_bank FREE on the next cycle; frame_rdy drops or moves to the other bank the same cycle.
  - frame_ack while frame_rdy=0 is ignored.
- Simultaneous commit (DRAIN end) and ack on the other bank: both take effect.
- rd_data reflects rd_addr from the previous cycle (1-cycle latency). Reads of a bank being written return undefined data.
- Both banks FULL: the FSM stays in IDLE with ready=0 until an ack. Frames are never overwritten.

Optional Feature:
- Macro: FFT_HALF_SPECTRUM_EN.
- Defined: only bins 0..FFT_N/2-1 are written, exploiting the symmetry of real input.
  - Beats FFT_N/2..FFT_N-1 are still accepted and framing-checked, but not written.
  - Each RAM bank depth is FFT_N/2, and rd_addr MSB is ignored.
- Undefined: all FFT_N bins are written; bank depth is FFT_N.

Test Plan:
- Reset, then one clean 128-beat frame with real=3, imag=4 on every beat: ready=1 throughout; 2 cycles after the last beat frame_rdy=1, rd_bank=0, frame_cnt=1; every rd_addr reads 25.
- eop asserted on beat 100: frame_err pulses 1 cycle; frame_rdy stays 0; frame_cnt unchanged; the next clean frame lands in bank 0.
- sop re-asserted on beat 50: frame_err pulses; the frame restarts; 128 beats after the second sop the bank commits with data from the second frame only.
- Three back-to-back frames, no ack: banks 0 and 1 fill; fft_src_ready=0 before frame 3; ack bank 0, then ready=1 and frame 3 goes into bank 0; rd_bank=1 after the ack.
- Extreme input real=-32768, imag=-32768: rd_data=2147483648 (0x80000000).
- sys_rst low mid-frame at beat 64: all outputs at reset values next cycle; the following full frame commits to bank 0 with frame_cnt=1.
